// File: rtl/result_writeback_ctrl.sv
// Frame result write-back: buffers processed pixels in a show-ahead FIFO
// and streams them to output memory in raster order, one frame per start.
module result_writeback_ctrl #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned NUM_PIX    = 262144
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [17:0]       mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              done
);

  localparam int unsigned CNT_W  = 19;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned FILL_W = PTR_W + 1;
  localparam int unsigned ADDR_W = 18;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    acc_cnt_q, acc_cnt_d;
  logic [CNT_W-1:0]    wr_cnt_q, wr_cnt_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [FILL_W-1:0]   fill_q, fill_d;
  logic [DATA_W-1:0]   fifo_mem_q [FIFO_DEPTH];

  logic fifo_full;
  logic fifo_empty;
  logic push;
  logic pop;

  // Handshake and status decode from registered state
  always_comb begin
    fifo_full  = (fill_q == FILL_W'(FIFO_DEPTH));
    fifo_empty = (fill_q == '0);
    in_ready   = (state_q == S_RUN) && !fifo_full && (acc_cnt_q < CNT_W'(NUM_PIX));
    mem_we     = ((state_q == S_RUN) || (state_q == S_DRAIN)) && !fifo_empty;
    push       = in_valid && in_ready;
    pop        = mem_we && mem_ready;
    mem_addr   = wr_cnt_q[ADDR_W-1:0];
    mem_wdata  = fifo_mem_q[rd_ptr_q];
    busy       = (state_q == S_RUN) || (state_q == S_DRAIN);
    done       = (state_q == S_DONE);
  end

  // Next-state: frame sequencing, counters and FIFO bookkeeping
  always_comb begin
    state_d   = state_q;
    acc_cnt_d = acc_cnt_q;
    wr_cnt_d  = wr_cnt_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    fill_d    = fill_q;

    if (push) begin
      wr_ptr_d  = wr_ptr_q + PTR_W'(1);
      acc_cnt_d = acc_cnt_q + CNT_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      wr_cnt_d = wr_cnt_q + CNT_W'(1);
    end
    case ({push, pop})
      2'b10:   fill_d = fill_q + FILL_W'(1);
      2'b01:   fill_d = fill_q - FILL_W'(1);
      default: fill_d = fill_q;
    endcase

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_RUN;
          acc_cnt_d = '0;
          wr_cnt_d  = '0;
          wr_ptr_d  = '0;
          rd_ptr_d  = '0;
          fill_d    = '0;
        end
      end
      S_RUN: begin
        if (push && (acc_cnt_q + CNT_W'(1) == CNT_W'(NUM_PIX))) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (fifo_empty && (wr_cnt_q == CNT_W'(NUM_PIX))) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q   <= S_IDLE;
      acc_cnt_q <= '0;
      wr_cnt_q  <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      fill_q    <= '0;
    end else begin
      state_q   <= state_d;
      acc_cnt_q <= acc_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      fill_q    <= fill_d;
    end
  end

  // FIFO storage; contents are don't-care until written
  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_mem_q[wr_ptr_q] <= in_data;
    end
  end

endmodule

// File: tb/tb_result_writeback_ctrl.sv
// Bench for result_writeback_ctrl: directed vector table, then model-checked
// streaming, backpressure, reset and random-traffic frames.
module tb_result_writeback_ctrl;

  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned NPIX  = 64;

  logic          CLK;
  logic          rst;
  logic          start;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          mem_we;
  logic [17:0]   mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ready;
  logic          busy;
  logic          done;

  result_writeback_ctrl #(
    .DATA_W(DW), .FIFO_DEPTH(DEPTH), .NUM_PIX(NPIX)
  ) dut (
    .CLK(CLK), .rst(rst), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .busy(busy), .done(done)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: a frame is "active" between start and completion;
  // pixels in flight are a queue, accepted/written counts are plain integers.
  bit            model_on = 0;
  bit            m_active = 0;
  bit            m_done   = 0;
  int            m_acc    = 0;
  int            m_wr     = 0;
  logic [DW-1:0] m_q[$];
  int            done_seen = 0;

  task automatic tick();
    bit push;
    bit pop;
    bit fin;
    #1;
    if (model_on) begin
      chk("in_ready", 32'(in_ready), 32'(m_active && m_acc < NPIX && m_q.size() < DEPTH));
      chk("mem_we",   32'(mem_we),   32'(m_active && m_q.size() > 0));
      chk("mem_addr", 32'(mem_addr), 32'(18'(m_wr)));
      chk("busy",     32'(busy),     32'(m_active));
      chk("done",     32'(done),     32'(m_done));
      if (mem_we && m_q.size() > 0) chk("mem_wdata", 32'(mem_wdata), 32'(m_q[0]));
    end
    push = in_valid && in_ready;
    pop  = mem_we && mem_ready && (m_q.size() > 0);
    if (done) done_seen++;
    @(posedge CLK);
    if (rst) begin
      m_active = 0; m_done = 0; m_acc = 0; m_wr = 0; m_q.delete();
    end else begin
      fin = m_active && m_acc == NPIX && m_wr == NPIX && m_q.size() == 0;
      if (m_done) m_done = 0;
      else if (!m_active && start) begin
        m_active = 1; m_acc = 0; m_wr = 0; m_q.delete();
      end
      if (pop) begin
        void'(m_q.pop_front());
        m_wr++;
      end
      if (push) begin
        m_q.push_back(in_data);
        m_acc++;
      end
      if (fin) begin
        m_active = 0;
        m_done   = 1;
      end
    end
    #1;
  endtask

  // mode 0: full-rate streaming with data = address; mode 1: random traffic
  task automatic run_until_done(input int mode, input int budget);
    int d0;
    d0 = done_seen;
    for (int i = 0; i < budget && done_seen == d0; i++) begin
      if (mode == 0) begin
        start = 1'b0; in_valid = 1'b1; mem_ready = 1'b1; in_data = 8'(m_acc);
      end else begin
        start     = ($urandom_range(0, 7) == 0);
        in_valid  = 1'($urandom_range(0, 1));
        mem_ready = 1'($urandom_range(0, 1));
        in_data   = 8'($urandom);
      end
      tick();
    end
    start = 1'b0; in_valid = 1'b1; mem_ready = 1'b1;
    tick();
    tick();
    chk("frame_done_pulses", 32'(done_seen - d0), 32'd1);
    chk("frame_writes", 32'(m_wr), 32'(NPIX));
  endtask

  task automatic begin_frame();
    start = 1'b1; in_valid = 1'b0; mem_ready = 1'b0;
    tick();
    start = 1'b0;
  endtask

  typedef struct {
    logic          rst;
    logic          start;
    logic          iv;
    logic [DW-1:0] d;
    logic          mr;
    logic          e_rdy;
    logic          e_we;
    logic [17:0]   e_addr;
    logic [DW-1:0] e_wd;
    logic          e_busy;
    logic          e_done;
  } vec_t;

  vec_t tbl[12];
  logic [17:0]   hold_addr;
  logic [DW-1:0] hold_data;

  initial begin
    //           rst   start iv    d      mr    rdy   we    addr    wd     busy  done
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 18'd0, 8'h00, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 18'd0, 8'h00, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 18'd0, 8'h00, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 18'd0, 8'hA5, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 8'h3C, 1'b1, 1'b1, 1'b0, 18'd1, 8'h00, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 8'h7E, 1'b0, 1'b1, 1'b1, 18'd1, 8'h3C, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 18'd1, 8'h3C, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 18'd1, 8'h3C, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 18'd2, 8'h7E, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 18'd3, 8'h00, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 18'd3, 8'h00, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 18'd0, 8'h00, 1'b0, 1'b0};

    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; mem_ready = 1'b0;
    repeat (2) @(posedge CLK);
    #1;

    // Directed vectors: reset values, latency, stall hold, ignored start, reset
    for (int i = 0; i < 12; i++) begin
      rst = tbl[i].rst; start = tbl[i].start; in_valid = tbl[i].iv;
      in_data = tbl[i].d; mem_ready = tbl[i].mr;
      #1;
      chk($sformatf("vec%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].e_rdy));
      chk($sformatf("vec%0d_mem_we", i),   32'(mem_we),   32'(tbl[i].e_we));
      chk($sformatf("vec%0d_mem_addr", i), 32'(mem_addr), 32'(tbl[i].e_addr));
      chk($sformatf("vec%0d_busy", i),     32'(busy),     32'(tbl[i].e_busy));
      chk($sformatf("vec%0d_done", i),     32'(done),     32'(tbl[i].e_done));
      if (tbl[i].e_we) chk($sformatf("vec%0d_mem_wdata", i), 32'(mem_wdata), 32'(tbl[i].e_wd));
      @(posedge CLK);
      #1;
    end

    model_on = 1;

    // Full-rate streaming frame
    begin_frame();
    run_until_done(0, 400);

    // Backpressure: memory stalled while input keeps offering
    begin_frame();
    for (int i = 0; i < 40; i++) begin
      in_valid = 1'b1; mem_ready = 1'b0; in_data = 8'(m_acc + 8'h40);
      if (i == 20) begin
        hold_addr = mem_addr;
        hold_data = mem_wdata;
      end
      tick();
    end
    chk("bp_accepted", 32'(m_acc), 32'(DEPTH));
    chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    chk("bp_addr_hold", 32'(mem_addr), 32'(hold_addr));
    chk("bp_data_hold", 32'(mem_wdata), 32'(hold_data));
    run_until_done(0, 400);

    // Reset mid-frame with entries queued, then a clean frame from address 0
    begin_frame();
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1; mem_ready = 1'b1; in_data = 8'($urandom); tick();
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; mem_ready = 1'b0; in_data = 8'($urandom); tick();
    end
    chk("rst_fifo_level_ge5", 32'(m_q.size() >= 5), 32'd1);
    rst = 1'b1; in_valid = 1'b1; mem_ready = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("rst_mem_we_low", 32'(mem_we), 32'd0);
    chk("rst_addr_zero", 32'(mem_addr), 32'd0);
    tick();
    begin_frame();
    run_until_done(0, 400);

    // Random valid/ready traffic with start pulses during the frame
    for (int f = 0; f < 3; f++) begin
      begin_frame();
      run_until_done(1, 2000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/result_writeback_ctrl.md
RESULT_WRITEBACK_CTRL -- requirements
Module: result_writeback_ctrl

Interface
REQ-001 Parameter DATA_W, default 8, pixel width in bits.
REQ-002 Parameter FIFO_DEPTH, default 16, elastic buffer entries; power of two, at least 4.
REQ-003 Parameter NUM_PIX, default 262144, pixels per frame (512x512).
REQ-004 CLK  input  1  clock; all logic on the rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 start  input  1  begin one frame write-back; sampled only in IDLE.
REQ-007 in_valid  input  1  processed pixel present on in_data.
REQ-008 in_data  input  DATA_W  processed pixel from the steer/filter pipeline.
REQ-009 in_ready  output  1  block accepts in_data this cycle.
REQ-010 mem_we  output  1  write request to external output memory.
REQ-011 mem_addr  output  18  write address, raster order.
REQ-012 mem_wdata  output  DATA_W  write data.
REQ-013 mem_ready  input  1  memory accepts the write this cycle.
REQ-014 busy  output  1  high in RUN and DRAIN.
REQ-015 done  output  1  one-cycle pulse on frame completion.

Function
REQ-016 States: IDLE, RUN, DRAIN, DONE; state held in a register.
REQ-017 IDLE->RUN when start=1; clears both counters and the FIFO. start is ignored in every other state.
REQ-018 Input accept: in_valid=1 and in_ready=1 at a rising edge pushes in_data into the FIFO and increments acc_cnt.
REQ-019 in_ready=1 only in RUN, with FIFO not full and acc_cnt<NUM_PIX. It is combinational from state, FIFO count and acc_cnt, and never depends on in_valid.
REQ-020 RUN->DRAIN on the edge on which acc_cnt reaches NUM_PIX.
REQ-021 FIFO is show-ahead: mem_wdata = FIFO head; mem_we = FIFO not empty, in RUN or DRAIN only.
REQ-022 mem_addr = wr_cnt register (18 bits), starting at 0.
REQ-023 Write completes when mem_we=1 and mem_ready=1 at an edge: pop the FIFO and increment wr_cnt.
REQ-024 While mem_we=1 and mem_ready=0, mem_addr and mem_wdata are held stable.
REQ-025 Latency: a pixel accepted into an empty FIFO at edge N is driven with mem_we=1 during cycle N+1.
REQ-026 Simultaneous push and pop: FIFO count is unchanged and order is preserved.
REQ-027 Full FIFO: in_ready=0. There is no same-cycle bypass of a pop into a push.
REQ-028 DRAIN->DONE when the FIFO is empty and wr_cnt=NUM_PIX.
REQ-029 DONE: done=1 for exactly one cycle, then DONE->IDLE.
REQ-030 Counter widths:
- acc_cnt and wr_cnt are 19 bits, so they hold the value NUM_PIX.
- mem_addr is wr_cnt[17:0].
- The counters do not wrap within a frame.
REQ-031 Output order equals input order: the k-th accepted pixel is written to address k.

Reset
REQ-032 rst=1 at an edge forces state IDLE and clears acc_cnt, wr_cnt, FIFO pointers and count, from any state including mid-frame.
REQ-033 Output values during and immediately after reset: in_ready=0, mem_we=0, mem_addr=0, busy=0, done=0. mem_wdata has no defined value while mem_we=0.
REQ-034 A frame interrupted by reset is discarded; the next start restarts at address 0.

Verification
REQ-035 Streaming, no stall. Stimulus: start; in_valid=1 with data=addr[7:0]; mem_ready=1 throughout. Required response: every address 0..262143 is written once with the matching data; done pulses once, 2 cycles after the last write handshake; busy then falls.
REQ-036 Backpressure. Stimulus: mem_ready=0 for 40 cycles with in_valid=1. Required response: exactly 16 pixels are accepted; in_ready=0 from the edge on which the count reaches 16; mem_addr and mem_wdata do not change. After mem_ready returns to 1, addresses continue with no gap.
REQ-037 Latency. Stimulus: with the FIFO empty, a single pixel 0xA5 is accepted at edge N. Required response: mem_we=1, mem_wdata=0xA5 and mem_addr equal to the current wr_cnt during cycle N+1.
REQ-038 Frame-end boundary. Stimulus: the 262144th pixel is accepted. Required response: in_ready=0 from the next cycle while in_valid stays 1; no write to any address at or above 262144.
REQ-039 Reset mid-frame. Stimulus: rst=1 at pixel 1000 with 5 entries in the FIFO, then a new start. Required response: mem_we=0 the cycle after reset; the next frame's first write is to address 0.
REQ-040 Ignored start and random traffic. Stimulus: start pulsed during RUN; random in_valid and mem_ready, 50% each. Required response: no restart; the written data sequence equals the input sequence exactly.
